// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction per req/ack handshake and presents it to decode.
// Optional MISALIGN_CHECK_EN adds fetch_fault and a terminal fault state for misaligned branch targets.
module instr_fetch_unit #(
  parameter int unsigned     ADDR_WIDTH   = 32,
  parameter int unsigned     DATA_WIDTH   = 32,
  parameter int unsigned     OPCODE_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic                    imem_ack,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic [DATA_WIDTH-1:0]   instr,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    branch_taken,
  input  logic [ADDR_WIDTH-1:0]   branch_target
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                    fetch_fault
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
`ifdef MISALIGN_CHECK_EN
    ,
    StFault
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                    valid_q, valid_d;
  logic                    req_q, req_d;
  logic                    fault_q, fault_d;
  logic                    retire;
  logic                    misaligned;
  logic [ADDR_WIDTH-1:0]   next_pc;

  assign retire  = valid_q && instr_ready;
  // Taken targets are always word-aligned before they reach the PC.
  assign next_pc = branch_taken ? {branch_target[ADDR_WIDTH-1:2], 2'b00}
                                : pc_q + ADDR_WIDTH'(4);

`ifdef MISALIGN_CHECK_EN
  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];
  assign misaligned         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    req_d   = req_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        state_d = StReq;
        req_d   = 1'b1;
      end
      StReq: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (retire) begin
          valid_d = 1'b0;
`ifdef MISALIGN_CHECK_EN
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = StFault;
          end else begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            state_d = StReq;
          end
`else
          pc_d    = next_pc;
          req_d   = 1'b1;
          state_d = StReq;
`endif
        end
      end
`ifdef MISALIGN_CHECK_EN
      StFault: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_WIDTH-1:0];
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

`ifdef MISALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault = fault_q ^ misaligned;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a main instance (RESET_PC=0) and a wrap instance
// (RESET_PC=0xFFFFFFFC) sharing clock and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ack, instr_valid, instr_ready, branch_taken;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, branch_target;
  logic [6:0]  opcode;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [6:0]  w_opcode;

`ifdef MISALIGN_CHECK_EN
  logic fetch_fault, w_fault;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
`ifdef MISALIGN_CHECK_EN
    ,
    .fetch_fault   (fetch_fault)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (1'b1),
    .imem_rdata    (32'h0000_0013),
    .instr         (w_instr),
    .opcode        (w_opcode),
    .instr_pc      (w_pc),
    .instr_valid   (w_valid),
    .instr_ready   (1'b1),
    .branch_taken  (1'b0),
    .branch_target (32'h0)
`ifdef MISALIGN_CHECK_EN
    ,
    .fetch_fault   (w_fault)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    step();
    step();

    // Reset values
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_ipc", instr_pc, 32'h0);
    check_eq("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    @(negedge clk);
    reset = 1'b1;

    // Cycle 1: request issued, ack in the same cycle
    step();
    check_eq("t1_req", imem_req, 1);
    check_eq("t1_addr", imem_addr, 32'h0);
    check_eq("t1_valid0", instr_valid, 0);
    check_eq("t5_addr0", w_addr, 32'hFFFF_FFFC);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0033;
    step();
    check_eq("t1_valid", instr_valid, 1);
    check_eq("t1_opcode", opcode, 7'h33);
    check_eq("t1_ipc", instr_pc, 32'h0);
    check_eq("t1_req_drop", imem_req, 0);
    check_eq("t5_valid", w_valid, 1);

    // Ready tied high, ack immediate: 0x4, 0x8
    instr_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      imem_rdata = 32'h0000_0100 + 32'(k);
      step();
      check_eq("t2_req", imem_req, 1);
      check_eq("t2_addr", imem_addr, 32'(4 * k));
      check_eq("t2_valid_lo", instr_valid, 0);
      if (k == 1) begin
        check_eq("t5_wrap_req", w_req, 1);
        check_eq("t5_wrap_addr", w_addr, 32'h0);
      end
      step();
      check_eq("t2_valid_hi", instr_valid, 1);
      check_eq("t2_ipc", instr_pc, 32'(4 * k));
      check_eq("t2_instr", instr, 32'h0000_0100 + 32'(k));
    end

    // HOLD with ready low: branch and stray ack ignored
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    imem_ack      = 1'b1;
    imem_rdata    = 32'hDEAD_BEEF;
    step();
    step();
    check_eq("t4_hold_valid", instr_valid, 1);
    check_eq("t4_hold_instr", instr, 32'h0000_0102);
    check_eq("t4_hold_addr", imem_addr, 32'h8);
    check_eq("t4_hold_req", imem_req, 0);
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    step();
    check_eq("t4_br_addr", imem_addr, 32'h40);
    check_eq("t4_br_req", imem_req, 1);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;

    // Delayed ack: address and request stable for 5 cycles
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t3_req", imem_req, 1);
      check_eq("t3_addr", imem_addr, 32'h40);
      check_eq("t3_valid", instr_valid, 0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    check_eq("t3_valid_hi", instr_valid, 1);
    check_eq("t3_ipc", instr_pc, 32'h40);
    check_eq("t3_opcode", opcode, 7'h13);

    // Misaligned taken target
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    step();
    check_eq("t4_mis_addr", imem_addr, 32'h40);
    check_eq("t4_mis_valid", instr_valid, 0);
`ifdef MISALIGN_CHECK_EN
    check_eq("t6_fault", fetch_fault, 1);
    check_eq("t6_fault_req", imem_req, 0);
`else
    check_eq("t4_mis_req", imem_req, 1);
`endif

    // Ready/branch while not valid are ignored
    branch_target = 32'h80;
    step();
    step();
    check_eq("t_rdy_ign_addr", imem_addr, 32'h40);
    check_eq("t_rdy_ign_valid", instr_valid, 0);
`ifdef MISALIGN_CHECK_EN
    check_eq("t6_fault_sticky", fetch_fault, 1);
    check_eq("t6_fault_req2", imem_req, 0);
`else
    check_eq("t_rdy_ign_req", imem_req, 1);
`endif
    instr_ready  = 1'b0;
    branch_taken = 1'b0;

    // Async reset mid-wait, pending ack discarded
    #2;
    imem_ack = 1'b1;
    reset    = 1'b0;
    #1;
    check_eq("t6_rst_req", imem_req, 0);
    check_eq("t6_rst_valid", instr_valid, 0);
    check_eq("t6_rst_addr", imem_addr, 32'h0);
    check_eq("t6_rst_instr", instr, 32'h0);
    check_eq("t6_rst_ipc", instr_pc, 32'h0);
`ifdef MISALIGN_CHECK_EN
    check_eq("t6_rst_fault", fetch_fault, 0);
`endif
    imem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    check_eq("t6_refetch_req", imem_req, 1);
    check_eq("t6_refetch_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
